// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
//   state_e         : responder FSM states (IDLE, BUSY, RESP)
//   DEFAULT_DEPTH   : default memory size in 32-bit words
//   DEFAULT_LATENCY : default cycles from accept to rsp_valid
//   WORD_OFFSET     : number of byte-address bits below the word index
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_DEPTH   = 256;
  localparam int unsigned DEFAULT_LATENCY = 2;
  localparam int unsigned WORD_OFFSET     = 2;

endpackage

// File: rtl/mem_array.sv
// Word RAM with synchronous byte-lane write and asynchronous read.
// Contents are not reset.
//   clk     : clock
//   we_i    : write strobe (qualified by be_i per lane)
//   addr_i  : word index used for both write and read
//   wdata_i : write data
//   be_i    : byte-lane enables, bit i selects bits [8*i+7:8*i]
//   rdata_o : word currently stored at addr_i
module mem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request in IDLE, waits
// LATENCY cycles, then presents a held response until the initiator takes it.
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake
//   req_we/addr/wdata/be    : request fields (byte address, byte enables)
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata, rsp_err      : read data (0 for writes/errors), error flag
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        op_we;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [3:0]  op_be;
  logic        op_err;
  logic        enter_resp;
  logic        mem_we;
  logic [31:0] mem_rdata;

  // With LATENCY = 1 the RESP entry coincides with the accept edge, before
  // the latches hold the request, so the live request fields are used then.
  always_comb begin
    if (state_q == IDLE) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_be    = req_be;
    end else begin
      op_we    = we_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      op_be    = be_q;
    end
    op_err = (op_addr[WORD_OFFSET-1:0] != '0) ||
             (32'(op_addr[31:WORD_OFFSET]) >= DEPTH);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data is sampled before the write lands, so it reflects memory
    // as it stood on entry to RESP.
    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = (op_err || op_we) ? '0 : mem_rdata;
    end
  end

  // Reset wins over a write that would otherwise commit on this edge.
  assign mem_we = rst_n && enter_resp && op_we && !op_err;

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (op_addr[WORD_OFFSET +: AW]),
    .wdata_i (op_wdata),
    .be_i    (op_be),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced idle while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);
  assign rsp_valid = rst_n && (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        r1_valid, r1_ready, r1_we, s1_valid, s1_ready, s1_err;
  logic [31:0] r1_addr, r1_wdata, s1_rdata;
  logic [3:0]  r1_be;

  int unsigned vectors;
  int unsigned miscompares;

  logic [31:0] ref_mem [256];

  mem_responder #(
    .DEPTH   (256),
    .LATENCY (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mem_responder #(
    .DEPTH   (256),
    .LATENCY (1)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (r1_valid),
    .req_ready (r1_ready),
    .req_we    (r1_we),
    .req_addr  (r1_addr),
    .req_wdata (r1_wdata),
    .req_be    (r1_be),
    .rsp_valid (s1_valid),
    .rsp_ready (s1_ready),
    .rsp_rdata (s1_rdata),
    .rsp_err   (s1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Reference behaviour: decide error/read data from the request alone and
  // apply a legal write to the model memory lane by lane.
  task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic err, output logic [31:0] rdata);
    int unsigned idx;
    idx   = addr / 4;
    err   = (addr % 4 != 0) || (idx >= 256);
    rdata = 32'h0;
    if (!err) begin
      if (!we) rdata = ref_mem[idx];
      else begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  // One complete transaction on the LATENCY=2 instance; the initiator
  // withholds rsp_ready for 'hold' cycles once the response is presented.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int unsigned hold);
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] first_rdata;
    int unsigned t;
    int unsigned lat;
    model_op(we, addr, wdata, be, e_err, e_rdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = (hold == 0);
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 32'(t < 20), 32'd1);
    @(posedge clk);
    #1;
    // Fields changing after the accept edge must have no effect.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    check("req_ready_busy", 32'(req_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 32'd2);
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_rdata", rsp_rdata, e_rdata);
    first_rdata = rsp_rdata;
    for (int k = 0; k < int'(hold); k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, first_rdata);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_ready", 32'(req_ready), 32'd1);
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
  endtask

  // Transaction on the LATENCY=1 instance, response taken immediately.
  task automatic do_req1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] e_rdata);
    int unsigned lat;
    @(negedge clk);
    r1_valid = 1'b1;
    r1_we    = we;
    r1_addr  = addr;
    r1_wdata = wdata;
    r1_be    = 4'hF;
    s1_ready = 1'b1;
    check("l1_ready", 32'(r1_ready), 32'd1);
    @(posedge clk);
    #1;
    r1_valid = 1'b0;
    r1_wdata = $urandom;
    lat = 1;
    while (!s1_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("l1_latency", lat, 32'd1);
    check("l1_err", 32'(s1_err), 32'd0);
    check("l1_rdata", s1_rdata, e_rdata);
    @(posedge clk);
    #1;
    check("l1_post_ready", 32'(r1_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    int unsigned sel;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    rst_n     = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    r1_valid  = 1'b0; r1_we  = 1'b0; r1_addr  = '0; r1_wdata  = '0; r1_be  = '0; s1_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 256; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 0);
    check("wr_rd_model", ref_mem[4], 32'hDEADBEEF);
    do_req(1'b1, 32'h10, 32'h11112222, 4'h3, 0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 0);
    check("partial_model", ref_mem[4], 32'hDEAD2222);

    do_req(1'b0, 32'h13, 32'h0, 4'hF, 0);
    do_req(1'b1, 32'h400, 32'h55AA55AA, 4'hF, 0);
    do_req(1'b0, 32'h0, 32'h0, 4'hF, 0);
    do_req(1'b1, 32'hC, 32'hFFFFFFFF, 4'h0, 0);
    do_req(1'b0, 32'hC, 32'h0, 4'hF, 0);
    do_req(1'b0, 32'h3FC, 32'h0, 4'hF, 0);

    do_req(1'b0, 32'h10, 32'h0, 4'hF, 5);

    // Reset while the write to 0x20 is still in BUSY.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstbusy_valid", 32'(rsp_valid), 32'd0);
    check("rstbusy_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("rstbusy_no_rsp", 32'(rsp_valid), 32'd0);
      check("rstbusy_idle", 32'(req_ready), 32'd1);
    end
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 0);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = ($urandom & 32'h3FC) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'h400 + ($urandom & 32'h0FFF_FFFC);
      else               a = 32'($urandom_range(0, 255)) * 4;
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    v = $urandom;
    do_req1(1'b1, 32'h14, v, 32'h0);
    do_req1(1'b0, 32'h14, 32'h0, v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
